// File: rtl/switch_unpack_if.sv
// =============================================================================
// switch_unpack_if : packed-word input and decoded-operand output bundle
// Revision: 1.0
// =============================================================================
`default_nettype none

interface switch_unpack_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_word;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_x;
  logic [7:0]       out_y;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in_word, in_mode, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_word, in_mode, out_ready,
    output in_ready, out_valid, out_x, out_y, out_err, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/switch_unpack.sv
// =============================================================================
// switch_unpack : nibble-swap unpacker with mode/sign check and result FIFO
// Optional error counter: define SWITCH_UNPACK_ERRCNT_EN
// Revision: 1.0
// =============================================================================
`default_nettype none

module switch_unpack #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  wire             clk,
  input  wire             rst_n,
  switch_unpack_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [16:0]   r_mem [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_x;
  logic [7:0]    w_y;
  logic          w_err;
  logic [16:0]   w_head;

  // in_ready depends only on the occupancy, so a full FIFO refuses a push
  // even when the consumer pops in the same cycle.
  assign bus.in_ready  = (r_count != c_full);
  assign bus.out_valid = (r_count != '0);
  assign w_push        = bus.in_valid && bus.in_ready;
  assign w_pop         = bus.out_valid && bus.out_ready;

  always_comb begin
    w_x   = 8'h00;
    w_y   = 8'h00;
    w_err = 1'b0;
    if (bus.in_mode) begin
      w_x   = {bus.in_word[3:0],  bus.in_word[11:8]};
      w_y   = {bus.in_word[7:4],  bus.in_word[15:12]};
      w_err = (bus.in_word[3] != bus.in_word[7]);
    end else begin
      w_x   = {bus.in_word[15:12], bus.in_word[7:4]};
      w_y   = {bus.in_word[11:8],  bus.in_word[3:0]};
      w_err = (bus.in_word[15] == bus.in_word[11]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_err, w_x, w_y};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  assign w_head      = bus.out_valid ? r_mem[r_rd_ptr] : 17'd0;
  assign bus.out_err = w_head[16];
  assign bus.out_x   = w_head[15:8];
  assign bus.out_y   = w_head[7:0];

`ifdef SWITCH_UNPACK_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_push && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_unpack.sv
// =============================================================================
// tb_switch_unpack : directed self-checking bench for switch_unpack
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_switch_unpack;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
`ifdef SWITCH_UNPACK_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   exp_cnt;

  switch_unpack_if #(.CNT_W(CNT_W)) bif ();

  switch_unpack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                            input logic ee);
    check({tag, "_valid"}, 32'(bif.out_valid), 32'd1);
    check({tag, "_x"},     32'(bif.out_x),     32'(ex));
    check({tag, "_y"},     32'(bif.out_y),     32'(ey));
    check({tag, "_err"},   32'(bif.out_err),   32'(ee));
  endtask

  task automatic check_cnt(input string tag);
    check(tag, 32'(bif.err_cnt), ERRCNT ? 32'(exp_cnt) : 32'd0);
  endtask

  // Reference decode straight from the packing formulas: {err, x, y}
  function automatic logic [16:0] ref_decode(input logic [15:0] w, input logic m);
    if (m) return {w[3] != w[7], w[3:0], w[11:8], w[7:4], w[15:12]};
    else   return {w[15] == w[11], w[15:12], w[7:4], w[11:8], w[3:0]};
  endfunction

  initial begin
    logic [15:0] w;
    logic        m;
    logic [16:0] e;

    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.in_word   = 16'h0000;
    bif.in_mode   = 1'b0;
    bif.out_ready = 1'b0;

    // T1 reset
    step();
    step();
    check("rst_out_valid", 32'(bif.out_valid), 32'd0);
    check("rst_in_ready",  32'(bif.in_ready),  32'd1);
    check("rst_out_x",     32'(bif.out_x),     32'd0);
    check_cnt("rst_err_cnt");
    rst_n = 1'b1;
    step();

    // T2..T4 back-to-back, each popped as the next is pushed
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    bif.in_word   = 16'h0F0F;
    bif.in_mode   = 1'b0;
    step();
    check_head("t2", 8'h00, 8'hFF, 1'b0);
    bif.in_word = 16'hF0F8;
    bif.in_mode = 1'b1;
    step();
    check_head("t3", 8'h80, 8'hFF, 1'b0);
    bif.in_word = 16'h0F0F;
    bif.in_mode = 1'b1;
    step();
    exp_cnt++;
    check_head("t4", 8'hFF, 8'h00, 1'b1);
    check_cnt("t4_err_cnt");
    bif.in_valid = 1'b0;
    bif.in_word  = 16'hFFFF;
    step();
    check("t4_empty_valid", 32'(bif.out_valid), 32'd0);
    check("t4_empty_x",     32'(bif.out_x),     32'd0);
    check("t4_empty_err",   32'(bif.out_err),   32'd0);

    // T5 fill with consumer stalled, refuse extra word, then drain
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    bif.in_word   = 16'h1234;
    bif.in_mode   = 1'b1;
    step();
    check("t5_ready_after_1", 32'(bif.in_ready), 32'd1);
    bif.in_word = 16'hABCD;
    bif.in_mode = 1'b0;
    step();
    exp_cnt++;
    check("t5_full_ready", 32'(bif.in_ready), 32'd0);
    check_cnt("t5_err_cnt");
    bif.in_word = 16'h5555;
    bif.in_mode = 1'b1;
    step();
    check("t5_still_full", 32'(bif.in_ready), 32'd0);
    check_head("t5_headA", 8'h42, 8'h31, 1'b0);
    bif.out_ready = 1'b1;
    step();
    check("t5_ready_after_pop", 32'(bif.in_ready), 32'd1);
    check_head("t5_headB", 8'hAC, 8'hBD, 1'b1);
    bif.in_valid = 1'b0;
    step();
    check("t5_drained", 32'(bif.out_valid), 32'd0);
    check_cnt("t5_refused_no_cnt");

    // T6 streaming with a mid-stream reset
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        rst_n = 1'b0;
        step();
        exp_cnt = 0;
        check("t6_rst_valid", 32'(bif.out_valid), 32'd0);
        check("t6_rst_ready", 32'(bif.in_ready),  32'd1);
        check_cnt("t6_rst_err_cnt");
        rst_n = 1'b1;
      end
      w = 16'(i * 16'h1357 + 16'h0246);
      m = (i % 2 == 1);
      e = ref_decode(w, m);
      bif.in_valid = 1'b1;
      bif.in_word  = w;
      bif.in_mode  = m;
      step();
      if (e[16]) exp_cnt++;
      check_head($sformatf("t6_w%0d", i), e[15:8], e[7:0], e[16]);
    end
    bif.in_valid = 1'b0;
    step();
    check("t6_end_valid", 32'(bif.out_valid), 32'd0);
    check_cnt("t6_end_err_cnt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
